exe_stage: RTL and testbench

Execute stage of the 5-stage ARM-subset pipeline: selects forwarded operands from the forwarding unit's select codes, generates the shifter operand, runs the ALU, keeps the NZCV status register and registers results into the EXE/MEM pipeline register. It sits between the ID/EXE register and the memory stage, and drives the branch redirect back to fetch.

---
 rtl/exe_pkg.sv | 44 ++++
 rtl/val2_generate.sv | 43 ++++
 rtl/exe_stage.sv | 168 ++++++++++++++++
 tb/tb_exe_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared constants for the execute stage
package exe_pkg;

    localparam int EXE_DW = 32;
    localparam int EXE_RW = 4;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_e;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        logic [3:0] f;
        f       = '0;
        f[SR_N] = n;
        f[SR_Z] = z;
        f[SR_C] = c;
        f[SR_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/val2_generate.sv
// rtl/val2_generate.sv - shifter operand (operand 2) generation
module val2_generate
    import exe_pkg::*;
#(
    parameter int DW = EXE_DW
) (
    input  logic          imm_in,
    input  logic          mem_en,
    input  logic [11:0]   shift_operand,
    input  logic [DW-1:0] rm_val,
    output logic [DW-1:0] val2
);

    logic [DW-1:0]   imm_ext;
    logic [2*DW-1:0] imm_dbl;
    logic [2*DW-1:0] rm_dbl;
    logic [4:0]      amt;
    logic [4:0]      rot;

    // Rotates are done as a right shift of the value concatenated with itself.
    always_comb begin
        imm_ext = {{(DW-8){1'b0}}, shift_operand[7:0]};
        rot     = {shift_operand[11:8], 1'b0};
        amt     = shift_operand[11:7];
        imm_dbl = {imm_ext, imm_ext} >> rot;
        rm_dbl  = {rm_val, rm_val} >> amt;
        val2    = rm_val;
        if (imm_in) begin
            val2 = imm_dbl[DW-1:0];
        end else if (mem_en) begin
            val2 = {{(DW-12){1'b0}}, shift_operand};
        end else begin
            case (shift_e'(shift_operand[6:5]))
                SHIFT_LSL: val2 = rm_val << amt;
                SHIFT_LSR: val2 = rm_val >> amt;
                SHIFT_ASR: val2 = $signed(rm_val) >>> amt;
                SHIFT_ROR: val2 = rm_dbl[DW-1:0];
                default:   val2 = rm_val;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: forwarding, ALU, NZCV register, EXE/MEM register
module exe_stage
    import exe_pkg::*;
#(
    parameter int DW = EXE_DW,
    parameter int RW = EXE_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          freeze,
    input  logic          valid_in,
    input  logic [DW-1:0] pc_in,
    input  logic [3:0]    exe_cmd,
    input  logic          s_in,
    input  logic          b_in,
    input  logic          imm_in,
    input  logic          mem_r_en_in,
    input  logic          mem_w_en_in,
    input  logic          wb_en_in,
    input  logic [11:0]   shift_operand,
    input  logic [23:0]   signed_imm_24,
    input  logic [DW-1:0] val_rn,
    input  logic [DW-1:0] val_rm,
    input  logic [RW-1:0] dest_in,
    input  logic [1:0]    val1_sel,
    input  logic [1:0]    val2_sel,
    input  logic [1:0]    st_val_sel,
    input  logic [DW-1:0] alu_res_mem,
    input  logic [DW-1:0] wb_value,
    output logic [DW-1:0] alu_res,
    output logic [DW-1:0] st_val,
    output logic [RW-1:0] dest,
    output logic          wb_en,
    output logic          mem_r_en,
    output logic          mem_w_en,
    output logic          valid,
    output logic [3:0]    status,
    output logic          branch_taken,
    output logic [DW-1:0] branch_addr
);

    logic [DW-1:0] val1, rm_fwd, st_fwd, val2;
    logic [DW:0]   sum;
    logic [DW-1:0] res;
    logic          c_flag, v_flag, c_in;

    logic [DW-1:0] alu_res_d, alu_res_q, st_val_d, st_val_q;
    logic [RW-1:0] dest_d, dest_q;
    logic          wb_en_d, wb_en_q, mem_r_en_d, mem_r_en_q;
    logic          mem_w_en_d, mem_w_en_q, valid_d, valid_q;
    logic [3:0]    status_d, status_q;

    // Select code 11 is unused by the forwarding unit and falls back to the register value.
    always_comb begin
        case (val1_sel)
            SEL_MEM: val1 = alu_res_mem;
            SEL_WB:  val1 = wb_value;
            default: val1 = val_rn;
        endcase
        case (val2_sel)
            SEL_MEM: rm_fwd = alu_res_mem;
            SEL_WB:  rm_fwd = wb_value;
            default: rm_fwd = val_rm;
        endcase
        case (st_val_sel)
            SEL_MEM: st_fwd = alu_res_mem;
            SEL_WB:  st_fwd = wb_value;
            default: st_fwd = val_rm;
        endcase
    end

    val2_generate #(.DW(DW)) u_val2 (
        .imm_in        (imm_in),
        .mem_en        (mem_r_en_in | mem_w_en_in),
        .shift_operand (shift_operand),
        .rm_val        (rm_fwd),
        .val2          (val2)
    );

    // Subtraction is a + ~b + 1 so the carry out is the ARM no-borrow flag.
    always_comb begin
        c_in   = status_q[SR_C];
        sum    = '0;
        res    = '0;
        c_flag = status_q[SR_C];
        v_flag = status_q[SR_V];
        case (exe_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD, CMD_ADC: begin
                sum    = {1'b0, val1} + {1'b0, val2}
                       + {{DW{1'b0}}, (exe_cmd == CMD_ADC) & c_in};
                res    = sum[DW-1:0];
                c_flag = sum[DW];
                v_flag = (val1[DW-1] == val2[DW-1]) && (res[DW-1] != val1[DW-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum    = {1'b0, val1} + {1'b0, ~val2}
                       + {{DW{1'b0}}, (exe_cmd == CMD_SUB) | c_in};
                res    = sum[DW-1:0];
                c_flag = sum[DW];
                v_flag = (val1[DW-1] != val2[DW-1]) && (res[DW-1] != val1[DW-1]);
            end
            CMD_AND: res = val1 & val2;
            CMD_ORR: res = val1 | val2;
            CMD_EOR: res = val1 ^ val2;
            default: res = '0;
        endcase
    end

    always_comb begin
        status_d   = status_q;
        alu_res_d  = alu_res_q;
        st_val_d   = st_val_q;
        dest_d     = dest_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        valid_d    = valid_q;
        if (!freeze) begin
            if (s_in && valid_in) begin
                status_d = pack_nzcv(res[DW-1], res == '0, c_flag, v_flag);
            end
            alu_res_d  = res;
            st_val_d   = st_fwd;
            dest_d     = dest_in;
            wb_en_d    = wb_en_in & valid_in;
            mem_r_en_d = mem_r_en_in & valid_in;
            mem_w_en_d = mem_w_en_in & valid_in;
            valid_d    = valid_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q   <= '0;
            alu_res_q  <= '0;
            st_val_q   <= '0;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            status_q   <= status_d;
            alu_res_q  <= alu_res_d;
            st_val_q   <= st_val_d;
            dest_q     <= dest_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            valid_q    <= valid_d;
        end
    end

    assign alu_res      = alu_res_q;
    assign st_val       = st_val_q;
    assign dest         = dest_q;
    assign wb_en        = wb_en_q;
    assign mem_r_en     = mem_r_en_q;
    assign mem_w_en     = mem_w_en_q;
    assign valid        = valid_q;
    assign status       = status_q;
    // A frozen slot is re-presented later, so redirect only once when it finally moves.
    assign branch_taken = b_in & valid_in & ~freeze;
    assign branch_addr  = pc_in + {{(DW-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - self-checking bench for exe_stage
module tb_exe_stage;

    localparam longint TWO32 = 64'sh1_0000_0000;
    localparam longint SMAX  = 64'sh7FFF_FFFF;
    localparam longint SMIN  = -64'sh8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, valid_in;
    logic [31:0] pc_in;
    logic [3:0]  exe_cmd;
    logic        s_in, b_in, imm_in, mem_r_en_in, mem_w_en_in, wb_en_in;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [31:0] val_rn, val_rm;
    logic [3:0]  dest_in;
    logic [1:0]  val1_sel, val2_sel, st_val_sel;
    logic [31:0] alu_res_mem, wb_value;
    logic [31:0] alu_res, st_val, branch_addr;
    logic [3:0]  dest, status;
    logic        wb_en, mem_r_en, mem_w_en, valid, branch_taken;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_alu, m_st;
    logic [3:0]  m_dest, m_status;
    logic        m_wb, m_mr, m_mw, m_valid;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .valid_in(valid_in), .pc_in(pc_in),
        .exe_cmd(exe_cmd), .s_in(s_in), .b_in(b_in), .imm_in(imm_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
        .val_rn(val_rn), .val_rm(val_rm), .dest_in(dest_in),
        .val1_sel(val1_sel), .val2_sel(val2_sel), .st_val_sel(st_val_sel),
        .alu_res_mem(alu_res_mem), .wb_value(wb_value),
        .alu_res(alu_res), .st_val(st_val), .dest(dest), .wb_en(wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .valid(valid), .status(status),
        .branch_taken(branch_taken), .branch_addr(branch_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [1:0] s, input logic [31:0] r);
        if (s == 2'b01) return alu_res_mem;
        if (s == 2'b10) return wb_value;
        return r;
    endfunction

    function automatic logic [31:0] m_val2();
        logic [31:0]        x;
        logic signed [31:0] sx;
        int                 n;
        if (imm_in) begin
            x = {24'b0, shift_operand[7:0]};
            n = 2 * int'(shift_operand[11:8]);
            return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
        end
        if (mem_r_en_in || mem_w_en_in) return {20'b0, shift_operand};
        x = m_fwd(val2_sel, val_rm);
        n = int'(shift_operand[11:7]);
        if (n == 0) return x;
        case (shift_operand[6:5])
            2'b00:   return x << n;
            2'b01:   return x >> n;
            2'b10:   begin sx = x; sx = sx >>> n; return sx; end
            default: return (x >> n) | (x << (32 - n));
        endcase
    endfunction

    function automatic logic ovf(input longint s);
        return (s > SMAX) || (s < SMIN);
    endfunction

    task automatic m_alu_eval(output logic [31:0] res, output logic [3:0] f);
        logic [31:0] a, b;
        longint      ua, ub, sa, sb, cin, brw;
        logic        c, v;
        a   = m_fwd(val1_sel, val_rn);
        b   = m_val2();
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        cin = m_status[1] ? 64'sd1 : 64'sd0;
        brw = 64'sd1 - cin;
        c   = m_status[1];
        v   = m_status[0];
        res = 32'h0;
        case (exe_cmd)
            4'b0001: res = b;
            4'b1001: res = ~b;
            4'b0010: begin res = 32'(ua + ub); c = (ua + ub) >= TWO32; v = ovf(sa + sb); end
            4'b0011: begin res = 32'(ua + ub + cin); c = (ua + ub + cin) >= TWO32; v = ovf(sa + sb + cin); end
            4'b0100: begin res = a - b; c = ua >= ub; v = ovf(sa - sb); end
            4'b0101: begin res = 32'(ua - ub - brw); c = ua >= (ub + brw); v = ovf(sa - sb - brw); end
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            default: res = 32'h0;
        endcase
        f = {res[31], res == 32'h0, c, v};
    endtask

    task automatic clear_inputs();
        freeze = 0; valid_in = 1; pc_in = 0; exe_cmd = 0; s_in = 0; b_in = 0;
        imm_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
        shift_operand = 0; signed_imm_24 = 0; val_rn = 0; val_rm = 0; dest_in = 0;
        val1_sel = 0; val2_sel = 0; st_val_sel = 0; alu_res_mem = 0; wb_value = 0;
    endtask

    task automatic model_reset();
        m_alu = 0; m_st = 0; m_dest = 0; m_status = 0;
        m_wb = 0; m_mr = 0; m_mw = 0; m_valid = 0;
    endtask

    task automatic step();
        logic [31:0] r, tgt;
        logic [3:0]  f;
        logic        bt;
        #1;
        m_alu_eval(r, f);
        bt = b_in && valid_in && !freeze;
        chk("branch_taken", {31'b0, branch_taken}, {31'b0, bt});
        if (bt) begin
            tgt = pc_in + 32'(int'($signed(signed_imm_24)) * 4);
            chk("branch_addr", branch_addr, tgt);
        end
        if (!freeze) begin
            m_alu   = r;
            m_st    = m_fwd(st_val_sel, val_rm);
            m_dest  = dest_in;
            m_valid = valid_in;
            m_wb    = valid_in & wb_en_in;
            m_mr    = valid_in & mem_r_en_in;
            m_mw    = valid_in & mem_w_en_in;
            if (valid_in && s_in) m_status = f;
        end
        @(posedge clk);
        #1;
        chk("alu_res", alu_res, m_alu);
        chk("st_val", st_val, m_st);
        chk("dest", {28'b0, dest}, {28'b0, m_dest});
        chk("ctrl", {28'b0, valid, wb_en, mem_r_en, mem_w_en}, {28'b0, m_valid, m_wb, m_mr, m_mw});
        chk("status", {28'b0, status}, {28'b0, m_status});
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, alu_res, 32'h0);
        chk(tag, st_val, 32'h0);
        chk(tag, {24'b0, dest, status}, 32'h0);
        chk(tag, {28'b0, valid, wb_en, mem_r_en, mem_w_en}, 32'h0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 0;
        #1;
        chk_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1;

        exe_cmd = 4'b0010; val1_sel = 2'b01; alu_res_mem = 5; val_rn = 99;
        val_rm = 3; wb_en_in = 1; dest_in = 7;
        step();
        chk("add_fwd", alu_res, 32'd8);
        chk("add_wb_en", {31'b0, wb_en}, 32'd1);

        clear_inputs();
        exe_cmd = 4'b0001; imm_in = 1; shift_operand = 12'h4FF;
        step();
        chk("mov_imm_rot", alu_res, 32'hFF00_0000);

        clear_inputs();
        exe_cmd = 4'b0010; s_in = 1; val_rn = 32'h7FFF_FFFF; val_rm = 1;
        step();
        chk("adds_ovf", {28'b0, status}, 32'b1001);

        clear_inputs();
        exe_cmd = 4'b0011;
        step();
        chk("adc_c0", alu_res, 32'd0);

        clear_inputs();
        exe_cmd = 4'b0100; s_in = 1; val_rn = 5; val_rm = 5;
        step();
        chk("subs_eq", {28'b0, status}, 32'b0110);

        clear_inputs();
        exe_cmd = 4'b0011;
        step();
        chk("adc_c1", alu_res, 32'd1);

        clear_inputs();
        exe_cmd = 4'b0100; s_in = 1; val_rn = 3; val_rm = 5;
        step();
        chk("subs_neg_n", {31'b0, status[3]}, 32'd1);
        chk("subs_neg_c", {31'b0, status[1]}, 32'd0);

        clear_inputs();
        valid_in = 0; wb_en_in = 1; mem_r_en_in = 1; s_in = 1; exe_cmd = 4'b0010; val_rn = 1;
        step();
        chk("bubble", {28'b0, valid, wb_en, mem_r_en, mem_w_en}, 32'h0);

        clear_inputs();
        exe_cmd = 4'b0010; mem_w_en_in = 1; shift_operand = 12'hABC; val_rn = 32'h1000;
        st_val_sel = 2'b10; wb_value = 32'hDEAD_BEEF; val_rm = 32'h1234;
        step();
        chk("str_addr", alu_res, 32'h0000_1ABC);
        chk("str_data", st_val, 32'hDEAD_BEEF);

        clear_inputs();
        freeze = 1; exe_cmd = 4'b0100; s_in = 1; b_in = 1; val_rn = 1; val_rm = 2;
        wb_en_in = 1; dest_in = 4'hC; pc_in = 32'h200; signed_imm_24 = 24'h10;
        for (int i = 0; i < 3; i++) step();
        chk("freeze_hold", alu_res, 32'h0000_1ABC);
        freeze = 0;
        step();
        chk("freeze_release", alu_res, 32'hFFFF_FFFF);

        clear_inputs();
        b_in = 1; pc_in = 32'h100; signed_imm_24 = 24'hFF_FFFF;
        exe_cmd = 4'b0111; val_rn = 32'h55; wb_en_in = 1; dest_in = 3;
        #1;
        chk("b_taken", {31'b0, branch_taken}, 32'd1);
        chk("b_addr", branch_addr, 32'h0000_00FC);
        step();
        rst = 0;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        rst = 1;

        for (int i = 0; i < 400; i++) begin
            freeze        = ($urandom_range(0, 7) == 0);
            valid_in      = ($urandom_range(0, 5) != 0);
            pc_in         = $urandom;
            exe_cmd       = 4'($urandom_range(0, 15));
            s_in          = 1'($urandom_range(0, 1));
            b_in          = ($urandom_range(0, 3) == 0);
            imm_in        = ($urandom_range(0, 3) == 0);
            mem_r_en_in   = ($urandom_range(0, 5) == 0);
            mem_w_en_in   = ($urandom_range(0, 5) == 0);
            wb_en_in      = 1'($urandom_range(0, 1));
            shift_operand = 12'($urandom);
            signed_imm_24 = 24'($urandom);
            val_rn        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            val_rm        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            dest_in       = 4'($urandom);
            val1_sel      = 2'($urandom);
            val2_sel      = 2'($urandom);
            st_val_sel    = 2'($urandom);
            alu_res_mem   = $urandom;
            wb_value      = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
